// File: rtl/ternary_popcount_accumulator_if.sv
// Handshake bundle for ternary_popcount_accumulator.
// Input beat channel: prod_i (N packed 2-bit ternary products), last_i,
// valid_i, ready_o. Result channel: acc_o, sat_o, err_o, beats_o, valid_o,
// ready_i.
// The slave modport is the accumulator; the master modport is the
// producer/consumer side around it.
interface ternary_popcount_accumulator_if #(
  parameter int N     = 72,
  parameter int ACC_W = 16
);
  logic [2*N-1:0]           prod_i;
  logic                     last_i;
  logic                     valid_i;
  logic                     ready_o;
  logic signed [ACC_W-1:0]  acc_o;
  logic                     sat_o;
  logic                     err_o;
  logic [15:0]              beats_o;
  logic                     valid_o;
  logic                     ready_i;

  modport slave (
    input  prod_i, last_i, valid_i, ready_i,
    output ready_o, acc_o, sat_o, err_o, beats_o, valid_o
  );

  modport master (
    output prod_i, last_i, valid_i, ready_i,
    input  ready_o, acc_o, sat_o, err_o, beats_o, valid_o
  );
endinterface

// File: rtl/ternary_popcount_accumulator.sv
// ternary_popcount_accumulator
// Accumulates (count of +1) - (count of -1) over a window of beats of N
// ternary products (00 = 0, 01 = -1, 10 = +1, 11 = illegal, counted as 0)
// into a saturating signed accumulator, and hands the window result to the
// next stage over valid/ready once the beat flagged last has been summed.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   bus    - slave side of ternary_popcount_accumulator_if
//            (beat in: prod_i/last_i/valid_i/ready_o,
//             result out: acc_o/sat_o/err_o/beats_o/valid_o/ready_i)
module ternary_popcount_accumulator #(
  parameter int N     = 72,
  parameter int ACC_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  ternary_popcount_accumulator_if.slave bus
);
  localparam int CW = $clog2(N + 1) + 1;

  typedef enum logic {RUN, HOLD} state_t;

  // Adds a beat difference to the accumulator at ACC_W+1 bits and clamps.
  // Returns {saturated, clamped_value}. The two top bits of the wide sum
  // disagree exactly when the result leaves the ACC_W signed range; the
  // extra sign bit tells which side it left on.
  function automatic logic [ACC_W:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [CW-1:0]    d
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W + 1 - CW){d[CW-1]}}, d};
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W] == 1'b0) sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      else                  sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      sat_add = {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  logic [CW-1:0]           pos_cnt;
  logic [CW-1:0]           neg_cnt;
  logic                    illegal;
  logic signed [CW-1:0]    diff_c;

  logic signed [CW-1:0]    diff_p1;
  logic                    last_p1;
  logic                    ill_p1;
  logic                    vld_p1;

  logic signed [ACC_W-1:0] acc_p2;
  logic [15:0]             cnt_p2;
  logic                    sat_p2;
  logic                    err_p2;

  logic signed [ACC_W-1:0] res_acc;
  logic                    res_sat;
  logic                    res_err;
  logic [15:0]             res_beats;
  state_t                  state;

  logic                    s1_adv;
  logic                    ready;
  logic                    accept;
  logic                    s2_go;
  logic [ACC_W:0]          sum_sat;
  logic [15:0]             cnt_next;

  always_comb begin
    pos_cnt = '0;
    neg_cnt = '0;
    illegal = 1'b0;
    for (int k = 0; k < N; k++) begin
      case (bus.prod_i[2*k +: 2])
        2'b10:   pos_cnt = pos_cnt + CW'(1);
        2'b01:   neg_cnt = neg_cnt + CW'(1);
        2'b11:   illegal = 1'b1;
        default: ;
      endcase
    end
    // Both counts are at most N < 2^(CW-1), so the difference fits CW signed.
    diff_c = $signed(pos_cnt - neg_cnt);
  end

  // Only a last beat waiting in S1 behind an unconsumed result blocks.
  assign s1_adv   = !(vld_p1 && last_p1 && (state == HOLD) && !bus.ready_i);
  assign ready    = !vld_p1 || s1_adv;
  assign accept   = bus.valid_i && ready;
  assign s2_go    = vld_p1 && s1_adv;
  assign sum_sat  = sat_add(acc_p2, diff_p1);
  assign cnt_next = (&cnt_p2) ? cnt_p2 : cnt_p2 + 16'd1;

  // ---- S1: popcount register ----
  always_ff @(posedge clk_i) begin
    if (accept) begin
      diff_p1 <= diff_c;
      last_p1 <= bus.last_i;
      ill_p1  <= illegal;
    end
  end

  // ---- S2: accumulate / output register and RUN/HOLD control ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1    <= 1'b0;
      acc_p2    <= '0;
      cnt_p2    <= '0;
      sat_p2    <= 1'b0;
      err_p2    <= 1'b0;
      res_acc   <= '0;
      res_sat   <= 1'b0;
      res_err   <= 1'b0;
      res_beats <= '0;
      state     <= RUN;
    end else begin
      if (ready) vld_p1 <= accept;

      if (s2_go && last_p1) begin
        res_acc   <= sum_sat[ACC_W-1:0];
        res_sat   <= sat_p2 | sum_sat[ACC_W];
        res_err   <= err_p2 | ill_p1;
        res_beats <= cnt_next;
        acc_p2    <= '0;
        cnt_p2    <= '0;
        sat_p2    <= 1'b0;
        err_p2    <= 1'b0;
        state     <= HOLD;
      end else begin
        if (s2_go) begin
          acc_p2 <= sum_sat[ACC_W-1:0];
          cnt_p2 <= cnt_next;
          sat_p2 <= sat_p2 | sum_sat[ACC_W];
          err_p2 <= err_p2 | ill_p1;
        end
        if (state == HOLD && bus.ready_i) state <= RUN;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = (state == HOLD);
  assign bus.acc_o   = res_acc;
  assign bus.sat_o   = res_sat;
  assign bus.err_o   = res_err;
  assign bus.beats_o = res_beats;

endmodule

// File: tb/tb_ternary_popcount_accumulator.sv
module tb_ternary_popcount_accumulator;
  localparam int N     = 8;
  localparam int ACC_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ternary_popcount_accumulator_if #(.N(N), .ACC_W(ACC_W)) bus_if ();

  ternary_popcount_accumulator #(.N(N), .ACC_W(ACC_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] p, input logic l);
    bus_if.prod_i  = p;
    bus_if.last_i  = l;
    bus_if.valid_i = 1'b1;
  endtask

  task automatic idle();
    bus_if.valid_i = 1'b0;
    bus_if.last_i  = 1'b0;
    bus_if.prod_i  = '0;
  endtask

  task automatic chk_res(input string tag, input int v, input int a,
                         input int s, input int e, input int b);
    chk({tag, "_valid"}, int'(bus_if.valid_o), v);
    chk({tag, "_acc"},   int'(bus_if.acc_o),   a);
    chk({tag, "_sat"},   int'(bus_if.sat_o),   s);
    chk({tag, "_err"},   int'(bus_if.err_o),   e);
    chk({tag, "_beats"}, int'(bus_if.beats_o), b);
  endtask

  logic [15:0] b2b_vec [4] = '{16'hAAAA, 16'h5555, 16'h0002, 16'h0006};
  int          b2b_exp [4] = '{8, -8, 1, 0};

  initial begin
    idle();
    bus_if.ready_i = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk_res("reset", 0, 0, 0, 0, 0);
    chk("reset_ready", int'(bus_if.ready_o), 1);
    rst = 1'b0;

    // -8 then +8 with last: window sums to 0 over two beats
    drive(16'h5555, 1'b0); tick();
    drive(16'hAAAA, 1'b1); tick();
    idle();                tick();
    chk_res("t1", 1, 0, 0, 0, 2);
    tick();
    chk("t1_drop", int'(bus_if.valid_o), 0);

    // 20 x +8 clamps at 127; next single -8 window is clean
    for (int i = 0; i < 20; i++) begin
      drive(16'hAAAA, i == 19);
      tick();
    end
    drive(16'h5555, 1'b1); tick();
    chk_res("t2_clamp", 1, 127, 1, 0, 20);
    idle(); tick();
    chk_res("t2_next", 1, -8, 0, 0, 1);
    tick();
    chk("t2_drop", int'(bus_if.valid_o), 0);

    // four 11 codes and four 00 codes
    drive(16'h00FF, 1'b1); tick();
    idle();                tick();
    chk_res("t3_illegal", 1, 0, 0, 1, 1);
    tick();

    // backpressure: A (+8) held while B (+1,+1,+1) builds up behind it
    bus_if.ready_i = 1'b0;
    drive(16'hAAAA, 1'b1); tick();
    drive(16'h0002, 1'b0); #1;
    chk("t4_rdy_b1", int'(bus_if.ready_o), 1);
    tick();
    chk_res("t4_a_out", 1, 8, 0, 0, 1);
    drive(16'h0002, 1'b0); #1;
    chk("t4_rdy_b2", int'(bus_if.ready_o), 1);
    tick();
    chk("t4_a_hold1", int'(bus_if.acc_o), 8);
    drive(16'h0002, 1'b1); #1;
    chk("t4_rdy_b3", int'(bus_if.ready_o), 1);
    tick();
    idle(); #1;
    chk("t4_stall", int'(bus_if.ready_o), 0);
    chk("t4_a_hold2", int'(bus_if.acc_o), 8);
    tick();
    chk("t4_stall2", int'(bus_if.ready_o), 0);
    chk_res("t4_a_hold3", 1, 8, 0, 0, 1);
    bus_if.ready_i = 1'b1; #1;
    chk("t4_release", int'(bus_if.ready_o), 1);
    tick();
    chk_res("t4_b_out", 1, 3, 0, 0, 3);
    tick();
    chk("t4_drop", int'(bus_if.valid_o), 0);

    // back-to-back single-beat windows, one result per cycle
    for (int i = 0; i < 4; i++) begin
      drive(b2b_vec[i], 1'b1);
      tick();
      if (i >= 1) chk_res($sformatf("t5_%0d", i - 1), 1, b2b_exp[i-1], 0, 0, 1);
    end
    idle(); tick();
    chk_res("t5_3", 1, b2b_exp[3], 0, 0, 1);
    tick();
    chk("t5_drop", int'(bus_if.valid_o), 0);

    // reset while HOLD with a partial accumulator behind the result
    bus_if.ready_i = 1'b0;
    drive(16'hAAAA, 1'b1); tick();
    drive(16'h0002, 1'b0); tick();
    drive(16'h0002, 1'b0); tick();
    chk("t6_pre_hold", int'(bus_if.valid_o), 1);
    idle();
    rst = 1'b1; tick();
    rst = 1'b0;
    chk_res("t6_reset", 0, 0, 0, 0, 0);
    chk("t6_reset_ready", int'(bus_if.ready_o), 1);
    bus_if.ready_i = 1'b1;
    drive(16'h0002, 1'b1); tick();
    idle();                tick();
    chk_res("t6_fresh", 1, 1, 0, 0, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ternary_popcount_accumulator.md
Name: ternary_popcount_accumulator

Overview:
- Consumes one beat per cycle of N 2-bit ternary products from a row of ternary multipliers: 00 = 0, 01 = -1, 10 = +1.
- Per beat, counts the +1 and -1 products with two popcounts and adds (pos - neg) into a saturating signed accumulator.
- After the beat flagged last, hands the window result to the threshold/output stage over a valid/ready handshake.
- Two-stage pipeline: popcount register, then accumulate/output register.

Parameters:
- N, 72, products per input beat.
- ACC_W, 16, signed accumulator and result width; must be at least CW+1.
- CW, $clog2(N+1)+1 (derived, localparam), signed width of the per-beat difference.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- prod_i  in  2*N  packed products; product k is prod_i[2k+1:2k].
- last_i  in  1  beat closes the accumulation window.
- valid_i  in  1  beat valid.
- ready_o  out  1  beat accepted when valid_i && ready_o.
- acc_o  out  ACC_W  signed window result.
- sat_o  out  1  saturation occurred at any point in this window.
- err_o  out  1  window contained at least one illegal 11 code.
- beats_o  out  16  number of beats in this window, saturating at 0xFFFF.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.

Behaviour:
- Reset values: ready_o=1, valid_o=0, acc_o=0, sat_o=0, err_o=0, beats_o=0. Internal accumulator, beat counter, sticky flags and S1 valid all cleared.
- Reset mid-window or while a result is pending discards everything; there is no partial flush.
- Stage S1 (on accept):
  - pos = count of 10 codes; neg = count of 01 codes.
  - Registers diff = pos - neg as CW-bit signed, plus last, a one-bit illegal flag (any 11 code, counted as 0), and s1_valid.
- Stage S2 runs when S1 is valid and may advance:
  - sum = acc + sign-extended diff, computed at ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1, clamp to the max and set sticky sat. If sum < -2^(ACC_W-1), clamp to the min and set sticky sat.
  - Sticky err |= illegal flag. Beat counter +1, saturating.
- Last beat in S2:
  - The clamped sum, the flags and the counter (including this beat) load into the output register; valid_o=1.
  - Accumulator, counter and sticky flags clear to 0 in the same cycle.
  - The next beat starts a fresh window with no bubble.
- Output holds stable while valid_o && !ready_i. valid_o drops on the handshake unless a new last beat loads in the same cycle; then it stays 1 with new data.
- Stall and ready rules:
  - s1_adv = !(s1_last && valid_o && !ready_i).
  - ready_o = !s1_valid || s1_adv, combinational from registered state and ready_i only, never from valid_i.
  - Non-last beats never stall. Only a last beat blocks behind an unconsumed result.
- Latency: a last beat accepted in cycle t gives valid_o=1 in cycle t+2. Sustained throughput is one beat per cycle when ready_i=1.
- A window of one beat (last_i on the first beat) is legal.
- Beats with valid_i=0 do not affect state.
- The block is also internally an FSM with states RUN and HOLD:
  - RUN: no pending result.
  - HOLD: valid_o=1.
  - RUN->HOLD on a last-beat load. HOLD->RUN on a handshake with no simultaneous load. HOLD->HOLD on a handshake with a simultaneous load.

Test Plan:
- N=8, ACC_W=8. Beats 0x5555 (all +1? no: 01 = -1, so all -1), then 0xAAAA (all +1) with last, ready_i=1. Required: acc_o=0, beats_o=2, sat_o=0, valid_o=1 at cycle t+2 for one cycle.
- N=8, ACC_W=8. 20 beats of 0xAAAA, last on the 20th. Required: acc_o=127 (clamped from 160), sat_o=1, beats_o=20. The next window of one 0x5555 beat gives acc_o=-8, sat_o=0.
- Illegal code: beat 0x00FF (four 11 codes, four 00 codes) with last. Required: acc_o=0, err_o=1.
- Backpressure with ready_i=0: window A (one last beat, +8), then window B (3 beats of +1 each, last on the 3rd). Required: A held stable, ready_o=1 for B beats 1-2, ready_o=0 while B's last sits in S1. Raising ready_i yields B: acc_o=3 in the cycle after A's handshake.
- Back-to-back single-beat last windows with ready_i=1. Required: one result per cycle, valid_o continuously 1, values match each beat.
- Assert rst_i for one cycle while in HOLD with a partial accumulator. Required: all outputs return to reset values next cycle, and the following window's result excludes pre-reset beats.
